// File: rtl/regs_bank_pkg.sv
// ----------------------------------------------------------------------------
// regs_bank_pkg
// Shared definitions for the register-bank write-port sequencer:
//   - bank control codes driven on the bank's control input
//   - link register index (r15)
//   - sequencer FSM state type
//   - address / data widths
// Optional feature macro used by regs_bank_ctrl: REGS_BANK_CTRL_SCOREBOARD_EN
// ----------------------------------------------------------------------------
package regs_bank_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = DATA_W / 2;

    // Bank control codes
    localparam logic [2:0] CTL_FULL  = 3'b000;
    localparam logic [2:0] CTL_LO    = 3'b001;
    localparam logic [2:0] CTL_HI    = 3'b010;
    localparam logic [2:0] CTL_LNK   = 3'b011;
    localparam logic [2:0] IDLE_CODE = 3'b111;

    localparam logic [ADDR_W-1:0] LINK_REG = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FULL,
        ST_LNK,
        ST_LI_LO,
        ST_LI_HI
    } state_t;

endpackage

// File: rtl/regs_bank_arb.sv
// ----------------------------------------------------------------------------
// regs_bank_arb
// Three-input arbiter: lnk has fixed top priority, wb and li share a
// round-robin pointer. Grants are combinational and qualified by i_en
// (the accept window). The pointer moves only on a wb or li grant.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_en            accept window open this cycle
//   i_wb_req        writeback request
//   i_li_req        immediate-load request
//   i_lnk_req       link request
//   o_wb_gnt        writeback grant
//   o_li_gnt        immediate-load grant
//   o_lnk_gnt       link grant
// ----------------------------------------------------------------------------
module regs_bank_arb
    import regs_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_wb_req,
    input  logic i_li_req,
    input  logic i_lnk_req,
    output logic o_wb_gnt,
    output logic o_li_gnt,
    output logic o_lnk_gnt
);

    // 0: wb preferred, 1: li preferred
    logic r_rr;
    logic w_shared_en;

    assign w_shared_en = i_en && !i_lnk_req;

    assign o_lnk_gnt = i_en && i_lnk_req;
    // A lone requester wins regardless of the pointer.
    assign o_wb_gnt  = w_shared_en && i_wb_req && (!i_li_req || !r_rr);
    assign o_li_gnt  = w_shared_en && i_li_req && (!i_wb_req ||  r_rr);

    // After a grant, favour the requester that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (o_wb_gnt || o_li_gnt) begin
            r_rr <= o_wb_gnt;
        end
    end

endmodule

// File: rtl/regs_bank_ctrl.sv
// ----------------------------------------------------------------------------
// regs_bank_ctrl
// Write-port sequencer for the 16x32 register bank. Serialises writeback
// (wb), two-half immediate load (li) and PC link (lnk) requests onto the
// bank's single write port. Commands appear one cycle after the transfer.
// Optional feature: REGS_BANK_CTRL_SCOREBOARD_EN enables read-hazard flags
// hz_a/hz_b; without it they are tied low and rd_a/rd_b are unused.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   wb_req/wb_addr/wb_data/wb_gnt     writeback handshake
//   li_req/li_addr/li_imm/li_gnt      immediate-load handshake
//   lnk_req/lnk_pc/lnk_gnt            link handshake
//   wr_addr/wr_data/wr_pc/wr_ctrl     bank write port (inpC/data/pc/control)
//   busy                              a command is being issued this cycle
//   rd_a/rd_b, hz_a/hz_b              read addresses and hazard flags
// ----------------------------------------------------------------------------
module regs_bank_ctrl
    import regs_bank_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_req,
    input  logic [3:0]        wb_addr,
    input  logic [31:0]       wb_data,
    output logic              wb_gnt,
    input  logic              li_req,
    input  logic [3:0]        li_addr,
    input  logic [31:0]       li_imm,
    output logic              li_gnt,
    input  logic              lnk_req,
    input  logic [31:0]       lnk_pc,
    output logic              lnk_gnt,
    output logic [3:0]        wr_addr,
    output logic [31:0]       wr_data,
    output logic [31:0]       wr_pc,
    output logic [2:0]        wr_ctrl,
    output logic              busy,
    input  logic [3:0]        rd_a,
    input  logic [3:0]        rd_b,
    output logic              hz_a,
    output logic              hz_b
);

    state_t                r_state;
    logic [2:0]            r_ctrl;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_data;
    logic [DATA_W-1:0]     r_pc;
    logic [HALF_W-1:0]     r_imm_hi;

    logic                  w_en;
    logic                  w_wb_gnt;
    logic                  w_li_gnt;
    logic                  w_lnk_gnt;

    // Accept window: closed during reset and during the low half of an li.
    assign w_en = !rst && (r_state != ST_LI_LO);

    regs_bank_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_en),
        .i_wb_req  (wb_req),
        .i_li_req  (li_req),
        .i_lnk_req (lnk_req),
        .o_wb_gnt  (w_wb_gnt),
        .o_li_gnt  (w_li_gnt),
        .o_lnk_gnt (w_lnk_gnt)
    );

    assign wb_gnt  = w_wb_gnt;
    assign li_gnt  = w_li_gnt;
    assign lnk_gnt = w_lnk_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ctrl   <= IDLE_CODE;
            r_addr   <= '0;
            r_data   <= '0;
            r_pc     <= '0;
            r_imm_hi <= '0;
        end else if (r_state == ST_LI_LO) begin
            // High half reuses the captured destination address.
            r_state <= ST_LI_HI;
            r_ctrl  <= CTL_HI;
            r_data  <= {{HALF_W{1'b0}}, r_imm_hi};
        end else if (w_lnk_gnt) begin
            r_state <= ST_LNK;
            r_ctrl  <= CTL_LNK;
            r_addr  <= LINK_REG;
            r_pc    <= lnk_pc;
        end else if (w_wb_gnt) begin
            r_state <= ST_FULL;
            r_ctrl  <= CTL_FULL;
            r_addr  <= wb_addr;
            r_data  <= wb_data;
        end else if (w_li_gnt) begin
            r_state  <= ST_LI_LO;
            r_ctrl   <= CTL_LO;
            r_addr   <= li_addr;
            r_data   <= {{HALF_W{1'b0}}, li_imm[HALF_W-1:0]};
            r_imm_hi <= li_imm[DATA_W-1:HALF_W];
        end else begin
            // Payload outputs hold their last values while idle.
            r_state <= ST_IDLE;
            r_ctrl  <= IDLE_CODE;
        end
    end

    assign wr_ctrl = r_ctrl;
    assign wr_addr = r_addr;
    assign wr_data = r_data;
    assign wr_pc   = r_pc;
    assign busy    = (r_state != ST_IDLE);

`ifdef REGS_BANK_CTRL_SCOREBOARD_EN
    logic [ADDR_W-1:0] w_dest;
    logic              w_inflight;

    always_comb begin
        w_dest     = (r_state == ST_LNK) ? LINK_REG : r_addr;
        w_inflight = (r_state != ST_IDLE);
    end

    assign hz_a = w_inflight && (rd_a == w_dest);
    assign hz_b = w_inflight && (rd_b == w_dest);
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{rd_a, rd_b};
    assign hz_a = 1'b0;
    assign hz_b = 1'b0;
`endif

endmodule

// File: tb/tb_regs_bank_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regs_bank_ctrl
// Directed steps followed by randomized traffic, each cycle compared
// against a transaction-level reference of the write-port sequencer.
// ----------------------------------------------------------------------------
module tb_regs_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_req;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_gnt;
    logic        li_req;
    logic [3:0]  li_addr;
    logic [31:0] li_imm;
    logic        li_gnt;
    logic        lnk_req;
    logic [31:0] lnk_pc;
    logic        lnk_gnt;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;
    logic [2:0]  wr_ctrl;
    logic        busy;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic        hz_a;
    logic        hz_b;

    regs_bank_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .wb_req  (wb_req),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .wb_gnt  (wb_gnt),
        .li_req  (li_req),
        .li_addr (li_addr),
        .li_imm  (li_imm),
        .li_gnt  (li_gnt),
        .lnk_req (lnk_req),
        .lnk_pc  (lnk_pc),
        .lnk_gnt (lnk_gnt),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_pc   (wr_pc),
        .wr_ctrl (wr_ctrl),
        .busy    (busy),
        .rd_a    (rd_a),
        .rd_b    (rd_b),
        .hz_a    (hz_a),
        .hz_b    (hz_b)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: expected bank port contents for the current cycle, plus
    // the pending high half of an accepted immediate load.
    logic [2:0]  m_ctrl;
    logic [3:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    bit          m_known   = 1'b0;
    bit          m_pref_li = 1'b0;
    bit          m_hi_pending = 1'b0;
    logic [15:0] m_hi_val;

    // Grants the reference awarded in the last step (drives requester holding).
    bit g_wb, g_li, g_lnk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        bit open;
        bit hza, hzb;
        @(negedge clk);
        if (m_known) begin
            chk("wr_ctrl", {29'd0, wr_ctrl}, {29'd0, m_ctrl});
            chk("busy", {31'd0, busy}, {31'd0, (m_ctrl != 3'b111)});
            chk("wr_addr", {28'd0, wr_addr}, {28'd0, m_addr});
            chk("wr_data", wr_data, m_data);
            chk("wr_pc", wr_pc, m_pc);
`ifdef REGS_BANK_CTRL_SCOREBOARD_EN
            hza = (m_ctrl != 3'b111) && (rd_a == m_addr);
            hzb = (m_ctrl != 3'b111) && (rd_b == m_addr);
`else
            hza = 1'b0;
            hzb = 1'b0;
`endif
            chk("hz_a", {31'd0, hz_a}, {31'd0, hza});
            chk("hz_b", {31'd0, hz_b}, {31'd0, hzb});
        end
        open  = !rst && !m_hi_pending;
        g_lnk = open && lnk_req;
        g_wb  = open && !lnk_req && wb_req && (!li_req || !m_pref_li);
        g_li  = open && !lnk_req && li_req && (!wb_req || m_pref_li);
        chk("lnk_gnt", {31'd0, lnk_gnt}, {31'd0, g_lnk});
        chk("wb_gnt", {31'd0, wb_gnt}, {31'd0, g_wb});
        chk("li_gnt", {31'd0, li_gnt}, {31'd0, g_li});

        if (rst) begin
            m_ctrl = 3'b111; m_addr = '0; m_data = '0; m_pc = '0;
            m_pref_li = 1'b0; m_hi_pending = 1'b0; m_known = 1'b1;
        end else if (m_hi_pending) begin
            m_ctrl = 3'b010; m_data = {16'h0, m_hi_val}; m_hi_pending = 1'b0;
        end else if (g_lnk) begin
            m_ctrl = 3'b011; m_addr = 4'd15; m_pc = lnk_pc;
        end else if (g_wb) begin
            m_ctrl = 3'b000; m_addr = wb_addr; m_data = wb_data; m_pref_li = 1'b1;
        end else if (g_li) begin
            m_ctrl = 3'b001; m_addr = li_addr; m_data = {16'h0, li_imm[15:0]};
            m_hi_val = li_imm[31:16]; m_hi_pending = 1'b1; m_pref_li = 1'b0;
        end else begin
            m_ctrl = 3'b111;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_req = 0; li_req = 0; lnk_req = 0;
        wb_addr = '0; wb_data = '0; li_addr = '0; li_imm = '0; lnk_pc = '0;
        rd_a = 4'd0; rd_b = 4'd1;

        // Reset for two cycles, then observe the idle reset state.
        step(); step();
        rst = 1'b0;
        step();

        // Lone writeback.
        wb_req = 1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF;
        step();
        wb_req = 0;
        step(); step();

        // Immediate load; a wb held during LI_LO must not be granted there.
        li_req = 1; li_addr = 4'd5; li_imm = 32'h12345678;
        step();
        li_req = 0;
        wb_req = 1; wb_addr = 4'd1; wb_data = 32'h0BADF00D;
        step();   // LI_LO
        step();   // LI_HI, wb accepted back-to-back
        wb_req = 0;
        step(); step();

        // All three requesting: lnk first, then wb/li alternating.
        lnk_req = 1; lnk_pc  = 32'h33333333;
        wb_req  = 1; wb_addr = 4'd2; wb_data = 32'hAAAA5555;
        li_req  = 1; li_addr = 4'd6; li_imm  = 32'hCAFEF00D;
        for (int i = 0; i < 10; i++) begin
            step();
            if (g_lnk) lnk_req = 0;
        end
        wb_req = 0; li_req = 0; lnk_req = 0;
        step(); step();

        // Reset during LI_LO drops the high half.
        li_req = 1; li_addr = 4'd7; li_imm = 32'hFEDCBA98;
        step();
        li_req = 0; rst = 1;
        step();
        rst = 0;
        step(); step();

        // Hazard flags across both li cycles.
        rd_a = 4'd9; rd_b = 4'd2;
        li_req = 1; li_addr = 4'd9; li_imm = 32'h0F0F1234;
        step();
        li_req = 0;
        step(); step(); step();

        // Randomized traffic: requesters hold until granted.
        for (int c = 0; c < 500; c++) begin
            if (!lnk_req || g_lnk) begin
                lnk_req = ($urandom_range(0, 5) == 0);
                lnk_pc  = $urandom;
            end
            if (!wb_req || g_wb) begin
                wb_req  = $urandom_range(0, 1);
                wb_addr = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                wb_data = $urandom;
            end
            if (!li_req || g_li) begin
                li_req  = $urandom_range(0, 1);
                li_addr = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                li_imm  = $urandom;
            end
            rst  = ($urandom_range(0, 39) == 0);
            rd_a = 4'($urandom_range(0, 3));
            rd_b = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            step();
        end
        rst = 0; wb_req = 0; li_req = 0; lnk_req = 0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regs_bank_ctrl.md
Name: regs_bank_ctrl

Overview:
Write-port sequencer for the 16x32 register bank. It takes write requests from three requesters and serializes them onto the bank's single write port, driving inpC/data/pc/control:
- wb: full 32-bit writeback.
- li: 32-bit immediate load, performed as two 16-bit half writes.
- lnk: PC link into r15.

It arbitrates between the requesters and sequences the two-cycle immediate load. It sits between the decode/execute stages and regs_bank.

Parameters:
IDLE_CODE, 3'b111, control code driven when no write is issued (bank ignores it)
CTL_FULL, 3'b000, bank code: full 32-bit write
CTL_LO, 3'b001, bank code: write data[15:0] into low half
CTL_HI, 3'b010, bank code: write data[15:0] into high half
CTL_LNK, 3'b011, bank code: write pc into r15

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous active-high reset
wb_req  in  1  writeback request valid
wb_addr  in  4  writeback destination register
wb_data  in  32  writeback data
wb_gnt  out  1  writeback accepted (combinational ready)
li_req  in  1  immediate-load request valid
li_addr  in  4  immediate-load destination register
li_imm  in  32  immediate value
li_gnt  out  1  immediate load accepted
lnk_req  in  1  link request valid
lnk_pc  in  32  PC value for r15
lnk_gnt  out  1  link accepted
wr_addr  out  4  to bank inpC
wr_data  out  32  to bank data
wr_pc  out  32  to bank pc
wr_ctrl  out  3  to bank control
busy  out  1  a command is being issued this cycle (state != IDLE)
rd_a  in  4  bank read address A (hazard check)
rd_b  in  4  bank read address B (hazard check)
hz_a  out  1  rd_a hits a register with a write in flight
hz_b  out  1  rd_b hits a register with a write in flight

Behaviour:
- Handshake is valid/ready. A transfer occurs at a posedge where req && gnt. Requesters hold req and payload stable until granted. Payload is captured at the transfer.
- FSM states: IDLE, FULL, LNK, LI_LO, LI_HI.
- Accept window: gnt may assert only in IDLE, FULL, LNK or LI_HI, i.e. every state except LI_LO. At most one gnt is high per cycle.
- Arbitration: lnk has fixed highest priority. wb and li share round-robin via pointer rr (0 = wb preferred). rr flips to favour the other requester after each wb or li grant. A lnk grant leaves rr unchanged. A lone requester is granted regardless of rr.
- Transitions:
  - On a transfer, next state is FULL (wb), LNK (lnk) or LI_LO (li).
  - With no transfer, any accept-window state goes to IDLE.
  - LI_LO always goes to LI_HI.
- Outputs are registered and present the command during the state cycle; the bank writes at the posedge ending that cycle.
  - FULL: wr_ctrl=CTL_FULL, wr_addr=addr, wr_data=data.
  - LNK: wr_ctrl=CTL_LNK, wr_pc=pc, wr_addr=4'd15.
  - LI_LO: wr_ctrl=CTL_LO, wr_data={16'h0, imm[15:0]}.
  - LI_HI: wr_ctrl=CTL_HI, wr_data={16'h0, imm[31:16]}, same wr_addr.
  - IDLE: wr_ctrl=IDLE_CODE; wr_addr, wr_data and wr_pc hold their last values.
- Latency: command appears 1 cycle after transfer. Throughput is 1 command/cycle; li occupies 2 cycles.
- Back-to-back: a new transfer in the final cycle of a command (FULL, LNK or LI_HI) issues in the next cycle with no bubble.
- Simultaneous wb+li+lnk: lnk is granted first, then wb/li by rr.
- An li or wb targeting r15 is legal and uses its normal codes.
- Reset: state=IDLE, wr_ctrl=IDLE_CODE, wr_addr=0, wr_data=0, wr_pc=0, rr=0, busy=0, all gnt=0 while rst=1.
- Reset during LI_LO or LI_HI aborts the sequence; the high half is not written and the accepted li is dropped, not replayed.

Optional Feature:
Macro: REGS_BANK_CTRL_SCOREBOARD_EN.
- Defined: a register counts as in flight when it is the destination of the current FULL/LI_LO/LI_HI state, or r15 in LNK. hz_a = (rd_a is in flight); hz_b likewise. This covers the LI_LO cycle, where the destination holds a half-written value.
- Undefined: hz_a and hz_b are tied to 0; rd_a and rd_b are unused.

Decomposition:
- Package regs_bank_pkg holds: the bank control codes (CTL_*, IDLE_CODE), the LINK_REG=4'd15 constant, the FSM state enum, and the address/data widths.
- One sub-module, regs_bank_arb: 3-input arbiter with fixed priority for lnk and round-robin for wb/li, plus the rr register and an enable input for the accept window. The FSM and output registers stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles -> wr_ctrl=3'b111, all gnt=0, busy=0, wr_addr=0.
- wb alone, addr=3, data=32'hDEADBEEF -> wb_gnt=1 in the request cycle; next cycle wr_ctrl=000, wr_addr=3, wr_data=32'hDEADBEEF, busy=1.
- li, addr=5, imm=32'h12345678 -> cycle+1: wr_ctrl=001, wr_data=32'h00005678; cycle+2: wr_ctrl=010, wr_data=32'h00001234; all gnt=0 during LI_LO.
- wb, li and lnk all held (pc=32'h33333333) -> grant order lnk, wb, li, then wb/li alternating. LNK cycle shows wr_ctrl=011, wr_addr=15, wr_pc=32'h33333333. No idle cycle between commands except LI_LO.
- rst asserted during LI_LO of li to addr=7 -> next cycle wr_ctrl=111, state IDLE, no 010 issued.
- With REGS_BANK_CTRL_SCOREBOARD_EN: li addr=9, rd_a=9, rd_b=2 -> hz_a=1 in both LI cycles, hz_b=0. Without the macro, hz_a=0.
